// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequences the PC, handshakes with a variable-latency
// instruction memory and writes (PC+4, instruction) pairs into IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] PC_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_HOLD     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] hold_reg, hold_next;
  logic [31:0] old_addr_reg, old_addr_next;
  logic [31:0] pc_out_reg, pc_out_next;
  logic [31:0] inst_reg, inst_next;
  logic        valid_reg, valid_next;
  logic        flush_reg, flush_next;

  logic        take_branch;
  logic [31:0] pc_inc;
  logic [31:0] target;

  assign take_branch = branch_i & ~stall_i;
  assign pc_inc      = pc_reg + 32'd4;
  assign target      = branch_target_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      hold_reg     <= 32'd0;
      old_addr_reg <= 32'd0;
      pc_out_reg   <= 32'd0;
      inst_reg     <= 32'd0;
      valid_reg    <= 1'b0;
      flush_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      hold_reg     <= hold_next;
      old_addr_reg <= old_addr_next;
      pc_out_reg   <= pc_out_next;
      inst_reg     <= inst_next;
      valid_reg    <= valid_next;
      flush_reg    <= flush_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    hold_next     = hold_reg;
    old_addr_next = old_addr_reg;
    pc_out_next   = pc_out_reg;
    inst_next     = inst_reg;
    valid_next    = 1'b0;
    flush_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          state_next = ST_REQ;
        end
      end

      ST_REQ: begin
        if (take_branch) begin
          pc_next    = target;
          flush_next = 1'b1;
          if (!imem_ack_i) begin
            // The outstanding request cannot be withdrawn; remember its address.
            old_addr_next = pc_reg;
            state_next    = ST_REDIRECT;
          end
        end else if (imem_ack_i) begin
          if (stall_i) begin
            hold_next  = imem_data_i;
            state_next = ST_HOLD;
          end else begin
            valid_next  = 1'b1;
            pc_out_next = pc_inc;
            inst_next   = imem_data_i;
            pc_next     = pc_inc;
          end
        end
      end

      ST_HOLD: begin
        if (take_branch) begin
          pc_next    = target;
          flush_next = 1'b1;
          state_next = ST_REQ;
        end else if (!stall_i) begin
          valid_next  = 1'b1;
          pc_out_next = pc_inc;
          inst_next   = hold_reg;
          pc_next     = pc_inc;
          state_next  = ST_REQ;
        end
      end

      ST_REDIRECT: begin
        // A branch that coincides with the stale ack needs no further waiting.
        if (take_branch) begin
          pc_next    = target;
          flush_next = 1'b1;
        end
        if (imem_ack_i) begin
          state_next = ST_REQ;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign imem_req_o  = (state_reg == ST_REQ) || (state_reg == ST_REDIRECT);
  assign imem_addr_o = (state_reg == ST_REDIRECT) ? old_addr_reg : pc_reg;
  assign PC_o        = pc_out_reg;
  assign inst_o      = inst_reg;
  assign valid_o     = valid_reg;
  assign flush_o     = flush_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a random-latency memory and random
// stall/branch/reset traffic, checked cycle by cycle against a behavioural model.
module tb_if_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid;
  logic        flush;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_ack_i      (imem_ack),
    .imem_data_i     (imem_data),
    .PC_o            (pc_out),
    .inst_o          (inst_out),
    .valid_o         (valid),
    .flush_o         (flush)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: "running" after start, an optional buffered word, and
  // an optional stale request whose response must be thrown away.
  bit          m_run;
  bit          m_have_buf;
  bit          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_buf;
  logic [31:0] m_stale_addr;
  logic        e_valid;
  logic        e_flush;
  logic [31:0] e_pc;
  logic [31:0] e_inst;
  int          mem_wait;
  bit          chk_on;

  task automatic model_step(input bit r, input bit st, input bit sl, input bit br,
                            input logic [31:0] tgt, input bit ak, input logic [31:0] dat);
    bit redirect;
    if (!r) begin
      m_run = 0; m_have_buf = 0; m_stale = 0;
      m_pc = TB_RESET_PC; m_buf = '0; m_stale_addr = '0;
      e_valid = 0; e_flush = 0; e_pc = '0; e_inst = '0;
      return;
    end
    e_valid  = 0;
    e_flush  = 0;
    redirect = br && !sl && m_run;
    if (!m_run) begin
      m_run = st;
    end else if (redirect) begin
      e_flush = 1;
      if (m_have_buf) begin
        m_have_buf = 0;
      end else if (!m_stale && !ak) begin
        m_stale      = 1;
        m_stale_addr = m_pc;
      end else if (m_stale && ak) begin
        m_stale = 0;
      end
      m_pc = tgt & ~32'd3;
    end else if (m_have_buf) begin
      if (!sl) begin
        e_valid = 1; m_pc = m_pc + 32'd4; e_pc = m_pc; e_inst = m_buf;
        m_have_buf = 0;
      end
    end else if (m_stale) begin
      if (ak) m_stale = 0;
    end else if (ak) begin
      if (sl) begin
        m_have_buf = 1; m_buf = dat;
      end else begin
        e_valid = 1; m_pc = m_pc + 32'd4; e_pc = m_pc; e_inst = dat;
      end
    end
  endtask

  task automatic run_phase(input int cycles, input int lat_lo, input int lat_hi,
                           input int stall_pct, input int br_pct, input int rst_pct,
                           input int start_pct);
    bit          exp_req;
    bit          ak;
    bit          r, st, sl, br;
    logic [31:0] dat, tgt;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      exp_req = m_run && !m_have_buf;
      if (chk_on) begin
        check_eq("req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check_eq("addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        check_eq("valid", {31'd0, valid}, {31'd0, e_valid});
        check_eq("flush", {31'd0, flush}, {31'd0, e_flush});
        check_eq("pc_out", pc_out, e_pc);
        check_eq("inst", inst_out, e_inst);
      end
      dat = $urandom();
      if (exp_req) begin
        if (mem_wait == 0) begin
          ak = 1;
          mem_wait = $urandom_range(lat_hi, lat_lo);
        end else begin
          ak = 0;
          mem_wait--;
        end
      end else begin
        // Spurious acks while no request is outstanding must be ignored.
        ak = ($urandom_range(3, 0) == 0);
      end
      r  = !($urandom_range(99, 0) < rst_pct);
      st = ($urandom_range(99, 0) < start_pct);
      sl = ($urandom_range(99, 0) < stall_pct);
      br = ($urandom_range(99, 0) < br_pct);
      if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 | $urandom_range(15, 0);
      else                           tgt = $urandom();
      rst = r; start = st; stall = sl; branch = br; branch_target = tgt;
      imem_ack = ak; imem_data = dat;
      model_step(r, st, sl, br, tgt, ak && exp_req, dat);
      if (!r) chk_on = 1;
    end
  endtask

  initial begin
    rst = 0; start = 0; stall = 0; branch = 0; branch_target = '0;
    imem_ack = 0; imem_data = '0;
    mem_wait = 0; chk_on = 0;
    model_step(0, 0, 0, 0, '0, 0, '0);

    run_phase(3,    0, 0,  0,  0,   100, 0);   // reset
    run_phase(40,   0, 0,  0,  0,   0,   50);  // back-to-back fetch, wrap from RESET_PC
    run_phase(60,   3, 3,  0,  0,   0,   20);  // fixed 3-cycle latency
    run_phase(200,  0, 4,  40, 0,   0,   20);  // heavy stalls
    run_phase(300,  0, 3,  20, 20,  0,   20);  // branches and redirects
    run_phase(1000, 0, 5,  25, 15,  2,   30);  // mixed traffic with resets
    run_phase(400,  0, 2,  10, 40,  1,   30);  // branch storms

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that feeds the IF/ID pipeline register. It sequences the PC, drives a request/acknowledge handshake to a variable-latency instruction memory or cache, and presents fetched (PC+4, instruction) pairs with a write strobe. It also redirects on taken branches, raising a one-cycle flush toward IF/ID, and holds a fetched instruction while the pipeline stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-low reset
start_i  in  1  begin fetching; sampled only in IDLE
stall_i  in  1  pipeline stall (hazard unit / data cache); high = do not deliver
branch_i  in  1  taken-branch redirect from ID; honoured only when stall_i=0
branch_target_i  in  32  redirect address; bits [1:0] forced to 0 internally
imem_req_o  out  1  instruction memory request
imem_addr_o  out  32  request address; equals internal pc
imem_ack_i  in  1  memory response valid; meaningful only while imem_req_o=1
imem_data_i  in  32  instruction word, valid with imem_ack_i
PC_o  out  32  fetched PC+4, to IF/ID PC input
inst_o  out  32  fetched instruction, to IF/ID inst input
valid_o  out  1  one-cycle strobe: PC_o/inst_o hold a new instruction (IF/ID write)
flush_o  out  1  one-cycle strobe: discard IF/ID contents (IF/ID flush)

Behaviour:
- Reset (rst_i=0 at an edge): pc<=RESET_PC; state<=IDLE; imem_req_o=0, valid_o=0, flush_o=0, PC_o=0, inst_o=0, hold buffer=0. Reset overrides all inputs. An ack arriving after reset is ignored.
- States: IDLE, REQ, HOLD, REDIRECT. imem_req_o=1 in REQ and REDIRECT, 0 otherwise. imem_addr_o=pc in REQ; in REDIRECT it holds the old in-flight address.
- IDLE: start_i=1 -> REQ. Otherwise remain. Ack is ignored in IDLE.
- REQ, no ack: keep req and addr stable (request may not be withdrawn).
- REQ, ack, stall_i=0, branch_i=0: next cycle valid_o=1, PC_o=pc+4, inst_o=imem_data_i; pc<=pc+4; stay REQ. A same-cycle-ack memory therefore sustains 1 instr/cycle.
- REQ, ack, stall_i=1: buffer imem_data_i; pc unchanged; -> HOLD; valid_o=0.
- HOLD: req=0. When stall_i=0: next cycle valid_o=1 with pc+4 and the buffered instruction; pc<=pc+4; -> REQ.
- Branch (branch_i=1 and stall_i=0) has priority over delivery in every non-IDLE state:
  - pc<=branch_target_i&~3.
  - flush_o=1 for exactly the next cycle.
  - valid_o=0 that cycle; any data acked this cycle or held in HOLD is discarded.
  - From REQ with ack this cycle, or from HOLD: -> REQ.
  - From REQ without ack: -> REDIRECT.
- REDIRECT: keep the old request until ack; discard the response (no valid_o); -> REQ at the new pc. A further branch in REDIRECT overwrites pc, raises flush_o again, and stays in REDIRECT.
- branch_i with stall_i=1 is ignored; the ID stage re-presents it.
- valid_o and flush_o are never both 1 in the same cycle.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- start_i is ignored outside IDLE; fetch runs until reset.
- PC_o/inst_o retain their last values when valid_o=0.

Test Plan:
- Reset then start_i with an always-ack memory returning addr^32'hA5A5_0000 -> imem_addr_o 0,4,8,…; valid_o high every cycle from the 2nd cycle after start; PC_o 4,8,12; inst_o matches.
- Memory with 3-cycle ack latency -> req/addr held stable for 3 cycles; one valid_o pulse per ack; no duplicate deliveries.
- Ack at addr 0x10 with stall_i=1 for 4 cycles -> valid_o=0 during the stall, req=0 in HOLD; one cycle after stall_i falls, valid_o=1, PC_o=0x14, inst_o=the buffered word; next request at 0x14.
- branch_i=1 with target 0x103 while a request to 0x20 is pending (ack 2 cycles later) -> flush_o pulse next cycle; the 0x20 response is dropped; the next request goes to 0x100; first delivery PC_o=0x104.
- branch_i=1 with stall_i=1 -> no flush_o, pc unchanged. Separately, RESET_PC=32'hFFFF_FFFC -> second request goes to 0x0.
- rst_i=0 mid-request, then an ack arrives -> outputs return to reset values; the ack is ignored; fetching resumes only after start_i.
